// File: rtl/alu_ctrl_pkg.sv
// Shared constants, decoded-entry record and buffer occupancy states for the
// ALU control decoder.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Control part of one decoded entry; the immediate is appended by the top
  // level because its width is a parameter there.
  typedef struct packed {
    logic [2:0] funct3;
    logic       funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_imm;
    logic       reg_write;
    logic       illegal;
  } alu_ctrl_t;

  localparam int unsigned ENTRY_CTRL_W = $bits(alu_ctrl_t);

  // Total buffered record width for a given ALU operand width.
  function automatic int unsigned entry_width(input int unsigned data_width);
    return ENTRY_CTRL_W + data_width;
  endfunction

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_ctrl_skid_buf.sv
// Generic 2-entry FIFO-ordered valid/ready buffer. The entry at the head is
// always held in head_q, so the output data path is a plain register.
module alu_ctrl_skid_buf
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ready_q;
  logic             push, pop;

  assign push      = in_valid & ready_q;
  assign pop       = (state_q != BUF_EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = head_q;

  // Occupancy transitions and head/tail data movement.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // in_ready is low here, so only a pop can happen: tail moves to head.
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // State and storage registers; in_ready is registered from the next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (state_d != BUF_FULL);
    end
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ALU front-end decoder: decodes RV32I OP / OP-IMM words into the ALU control
// pair, register addresses and immediate, buffers them two deep and counts
// words the ALU cannot execute.
module alu_ctrl_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_funct3,
  output logic                  out_funct7,
  output logic [4:0]            out_rs1_addr,
  output logic [4:0]            out_rs2_addr,
  output logic [4:0]            out_rd_addr,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_use_imm,
  output logic                  out_reg_write,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  localparam int unsigned ENTRY_W = entry_width(DATA_WIDTH);

  logic [6:0]            opcode;
  logic [6:0]            funct7_f;
  logic [2:0]            funct3_f;
  logic [4:0]            rs1_f, rs2_f, rd_f;
  logic                  legal_r, legal_i, legal;
  alu_ctrl_t             dec_ctrl, head_ctrl;
  logic [DATA_WIDTH-1:0] dec_imm, head_imm;
  logic [ENTRY_W-1:0]    buf_in, buf_out;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign opcode   = in_instr[6:0];
  assign rd_f     = in_instr[11:7];
  assign funct3_f = in_instr[14:12];
  assign rs1_f    = in_instr[19:15];
  assign rs2_f    = in_instr[24:20];
  assign funct7_f = in_instr[31:25];

  assign legal_r = (opcode == OPC_OP) &&
                   (((funct7_f == F7_BASE) && ((funct3_f == F3_ADD) || (funct3_f == F3_OR))) ||
                    ((funct7_f == F7_ALT)  &&  (funct3_f == F3_ADD)));
  assign legal_i = (opcode == OPC_OP_IMM) && ((funct3_f == F3_ADD) || (funct3_f == F3_OR));
  assign legal   = legal_r | legal_i;

  // Field decode: illegal words clear the ALU control pair and write-back but
  // keep their address fields.
  always_comb begin
    dec_ctrl           = '0;
    dec_ctrl.rs1       = rs1_f;
    dec_ctrl.rd        = rd_f;
    dec_ctrl.rs2       = legal_i ? 5'd0 : rs2_f;
    dec_ctrl.funct3    = legal ? funct3_f : 3'b000;
    dec_ctrl.funct7    = legal_r & in_instr[30];
    dec_ctrl.use_imm   = legal_i;
    dec_ctrl.reg_write = legal & (rd_f != 5'd0);
    dec_ctrl.illegal   = ~legal;
    dec_imm            = (opcode == OPC_OP) ? '0 : DATA_WIDTH'(signed'(in_instr[31:20]));
  end

  assign buf_in = {dec_ctrl, dec_imm};

  alu_ctrl_skid_buf #(
    .WIDTH(ENTRY_W)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign {head_ctrl, head_imm} = buf_out;

  assign out_funct3    = head_ctrl.funct3;
  assign out_funct7    = head_ctrl.funct7;
  assign out_rs1_addr  = head_ctrl.rs1;
  assign out_rs2_addr  = head_ctrl.rs2;
  assign out_rd_addr   = head_ctrl.rd;
  assign out_use_imm   = head_ctrl.use_imm;
  assign out_reg_write = head_ctrl.reg_write;
  assign out_illegal   = head_ctrl.illegal;
  assign out_imm       = head_imm;

  assign accept = in_valid & in_ready;

  // Saturating count of accepted illegal words.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_ctrl.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Illegal counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed literal checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_alu_ctrl_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_funct3;
  logic        out_funct7;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [15:0] out_imm;
  logic        out_use_imm, out_reg_write, out_illegal;
  logic [7:0]  illegal_count;

  alu_ctrl_decoder #(
    .DATA_WIDTH(16),
    .CNT_WIDTH (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7),
    .out_rs1_addr (out_rs1_addr),
    .out_rs2_addr (out_rs2_addr),
    .out_rd_addr  (out_rd_addr),
    .out_imm      (out_imm),
    .out_use_imm  (out_use_imm),
    .out_reg_write(out_reg_write),
    .out_illegal  (out_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] imm;
    logic        use_imm, rw, ill;
  } exp_t;

  exp_t mq[$];
  exp_t h;
  int   mcnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  bit   do_pop, do_push;
  exp_t e_new;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_SUB  = 32'h407302B3;
  localparam logic [31:0] W_ADDI = 32'hFFF00093;
  localparam logic [31:0] W_ORI  = 32'h7F016113;
  localparam logic [31:0] W_XOR  = 32'h003140B3;

  // Mnemonic-level reference: classify the word, then derive each field.
  function automatic exp_t mdl(input logic [31:0] w);
    exp_t        e;
    int          kind;
    logic [16:0] key;
    key = {w[31:25], w[14:12], w[6:0]};
    casez (key)
      17'b0000000_000_0110011, 17'b0100000_000_0110011, 17'b0000000_110_0110011: kind = 1;
      17'b???????_000_0010011, 17'b???????_110_0010011:                          kind = 2;
      default:                                                                   kind = 0;
    endcase
    e.rs1     = w[19:15];
    e.rd      = w[11:7];
    e.ill     = (kind == 0);
    e.f3      = (kind != 0) ? w[14:12] : 3'b000;
    e.f7      = (kind == 1) ? w[30] : 1'b0;
    e.use_imm = (kind == 2);
    e.rs2     = (kind == 2) ? 5'd0 : w[24:20];
    e.rw      = (kind != 0) && (w[11:7] != 5'd0);
    e.imm     = (w[6:0] == 7'b0110011) ? 16'h0000 : {{4{w[31]}}, w[31:20]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each active edge from the inputs the bench drove.
  always @(posedge clk) begin
    if (reset_n) begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < 2);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e_new = mdl(in_instr);
        mq.push_back(e_new);
        if (e_new.ill && mcnt < 255) mcnt++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("illegal_count", 32'(illegal_count), 32'(mcnt));
      if (mq.size() != 0) begin
        h = mq[0];
        chk("funct3", 32'(out_funct3), 32'(h.f3));
        chk("funct7", 32'(out_funct7), 32'(h.f7));
        chk("rs1", 32'(out_rs1_addr), 32'(h.rs1));
        chk("rs2", 32'(out_rs2_addr), 32'(h.rs2));
        chk("rd", 32'(out_rd_addr), 32'(h.rd));
        chk("imm", 32'(out_imm), 32'(h.imm));
        chk("use_imm", 32'(out_use_imm), 32'(h.use_imm));
        chk("reg_write", 32'(out_reg_write), 32'(h.rw));
        chk("illegal", 32'(out_illegal), 32'(h.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one word until accepted (bounded); returns at posedge+1 after the accepting edge.
  task automatic offer(input logic [31:0] w);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int unsigned i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic head_lit(input string tag, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [15:0] imm, input logic ui, input logic rw, input logic il);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_f3"}, 32'(out_funct3), 32'(f3));
    chk({tag, "_f7"}, 32'(out_funct7), 32'(f7));
    chk({tag, "_rs1"}, 32'(out_rs1_addr), 32'(rs1));
    chk({tag, "_rs2"}, 32'(out_rs2_addr), 32'(rs2));
    chk({tag, "_rd"}, 32'(out_rd_addr), 32'(rd));
    chk({tag, "_imm"}, 32'(out_imm), 32'(imm));
    chk({tag, "_use_imm"}, 32'(out_use_imm), 32'(ui));
    chk({tag, "_reg_write"}, 32'(out_reg_write), 32'(rw));
    chk({tag, "_illegal"}, 32'(out_illegal), 32'(il));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    mq.delete();
    mcnt = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(illegal_count), 32'd0);
    chk("rst_rd", 32'(out_rd_addr), 32'd0);
    chk("rst_imm", 32'(out_imm), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    #1 reset_n = 1'b1;
  endtask

  logic [31:0] w;

  initial begin
    // Power-on reset.
    @(negedge clk);
    @(negedge clk);
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_in_ready", 32'(in_ready), 32'd1);
    chk("por_count", 32'(illegal_count), 32'd0);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // add x3,x1,x2
    offer(W_ADD);
    @(negedge clk);
    head_lit("add", 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
    drain();

    // sub x5,x6,x7
    offer(W_SUB);
    @(negedge clk);
    head_lit("sub", 3'b000, 1'b1, 5'd6, 5'd7, 5'd5, 16'h0000, 1'b0, 1'b1, 1'b0);
    drain();

    // addi x1,x0,-1 and ori x2,x2,0x7F0
    offer(W_ADDI);
    @(negedge clk);
    head_lit("addi", 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    drain();
    offer(W_ORI);
    @(negedge clk);
    head_lit("ori", 3'b110, 1'b0, 5'd2, 5'd0, 5'd2, 16'h07F0, 1'b1, 1'b1, 1'b0);
    drain();

    // xor is illegal; counter 0 -> 1
    @(negedge clk);
    chk("xor_cnt_before", 32'(illegal_count), 32'd0);
    offer(W_XOR);
    @(negedge clk);
    head_lit("xor", 3'b000, 1'b0, 5'd2, 5'd3, 5'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("xor_cnt_after", 32'(illegal_count), 32'd1);
    drain();

    // Drive the counter to all-ones, then one more illegal word must not wrap.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 260; i++) offer(W_XOR);
    @(negedge clk);
    chk("sat_cnt", 32'(illegal_count), 32'd255);
    offer(W_XOR);
    @(negedge clk);
    chk("sat_cnt_hold", 32'(illegal_count), 32'd255);
    drain();

    // Back-pressure: two accepted, third held with stable outputs.
    offer(W_ADD);
    offer(W_SUB);
    in_valid = 1'b1;
    in_instr = W_ORI;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      head_lit("bp_hold", 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    head_lit("bp_second", 3'b000, 1'b1, 5'd6, 5'd7, 5'd5, 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    head_lit("bp_third", 3'b110, 1'b0, 5'd2, 5'd0, 5'd2, 16'h07F0, 1'b1, 1'b1, 1'b0);
    chk("bp_push_pop_ready", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 1'b0;
    cyc();

    // Reset mid-transfer with two entries buffered and count 3.
    pulse_reset();
    cyc();
    out_ready = 1'b1;
    offer(W_XOR);
    cyc();
    out_ready = 1'b0;
    offer(W_XOR);
    offer(W_XOR);
    @(negedge clk);
    chk("pre_rst_count", 32'(illegal_count), 32'd3);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    mq.delete();
    mcnt = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(illegal_count), 32'd0);
    chk("mid_rst_imm", 32'(out_imm), 32'd0);
    #1 reset_n = 1'b1;
    in_valid = 1'b1;
    in_instr = W_ADD;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    head_lit("post_rst", 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
    drain();

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 3000; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    w[6:0] = 7'b0110011;
        2:       w[6:0] = 7'b0010011;
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0:       w[14:12] = 3'b000;
        1:       w[14:12] = 3'b110;
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'b0000000;
        1:       w[31:25] = 7'b0100000;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      in_instr  = w;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(); cyc(); cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
